// File: rtl/br_issue_queue_pkg.sv
// Shared RV32I decode types plus the branch issue-queue entry layout.
package rv32i_types;

  localparam int PREG_BITS = 6;
  localparam int ROB_BITS  = 4;

  typedef enum logic [6:0] {
    op_b_lui   = 7'b0110111,
    op_b_auipc = 7'b0010111,
    op_b_jal   = 7'b1101111,
    op_b_jalr  = 7'b1100111,
    op_b_br    = 7'b1100011,
    op_b_load  = 7'b0000011,
    op_b_store = 7'b0100011,
    op_b_imm   = 7'b0010011,
    op_b_reg   = 7'b0110011
  } rv32i_opcode;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic [31:0] imm;
  } decode_info_t;

  // Physical tag 0 is hardwired x0: always ready, never woken by the CDB.
  localparam logic [PREG_BITS-1:0] PREG_ZERO = '0;

  typedef struct packed {
    logic                 valid;
    decode_info_t         decode_info;
    logic [PREG_BITS-1:0] ps1;
    logic                 ps1_rdy;
    logic [PREG_BITS-1:0] ps2;
    logic                 ps2_rdy;
    logic [PREG_BITS-1:0] pd;
    logic [ROB_BITS-1:0]  rob_idx;
  } br_iq_entry_t;

endpackage

// File: rtl/br_iq_wakeup.sv
// Operand wakeup: a ready bit only ever sets, on a CDB match of a non-zero tag.
module br_iq_wakeup
  import rv32i_types::*;
#(
  parameter int W = PREG_BITS
) (
  input  logic [W-1:0] tag_i,
  input  logic         rdy_i,
  input  logic         cdb_valid_i,
  input  logic [W-1:0] cdb_pd_i,
  output logic         rdy_o
);
  assign rdy_o = rdy_i | (cdb_valid_i && (cdb_pd_i == tag_i) && (tag_i != '0));
endmodule

// File: rtl/br_issue_queue.sv
// In-order branch issue queue: circular buffer, CDB wakeup, oldest-only issue.
// Optional macro BR_ISSUE_QUEUE_FULL_PASS_EN: a full queue accepts dispatch while the head issues.
module br_issue_queue
  import rv32i_types::*;
#(
  parameter int PHYS_REG_BITS = PREG_BITS,
  parameter int ROB_IDX_BITS  = ROB_BITS,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dispatch_valid,
  output logic                     dispatch_ready,
  input  decode_info_t             dispatch_info,
  input  logic [PHYS_REG_BITS-1:0] dispatch_ps1,
  input  logic                     dispatch_ps1_rdy,
  input  logic [PHYS_REG_BITS-1:0] dispatch_ps2,
  input  logic                     dispatch_ps2_rdy,
  input  logic [PHYS_REG_BITS-1:0] dispatch_pd,
  input  logic [ROB_IDX_BITS-1:0]  dispatch_rob_idx,
  input  logic                     cdb_valid,
  input  logic [PHYS_REG_BITS-1:0] cdb_pd,
  input  logic                     issue_ready,
  output logic                     issue_valid,
  output decode_info_t             issue_info,
  output logic [PHYS_REG_BITS-1:0] issue_ps1,
  output logic [PHYS_REG_BITS-1:0] issue_ps2,
  output logic [PHYS_REG_BITS-1:0] issue_pd,
  output logic [ROB_IDX_BITS-1:0]  issue_rob_idx,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  br_iq_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] wk1, wk2;
  logic             is_jal, is_jalr, d1_base, d2_base, d1_rdy, d2_rdy;
  logic             push, pop;
  br_iq_entry_t     head;

  assign head  = ent_q[head_q];
  assign count = count_q;

  assign issue_valid = (count_q != '0) && head.ps1_rdy && head.ps2_rdy && issue_ready && !flush;
`ifdef BR_ISSUE_QUEUE_FULL_PASS_EN
  assign dispatch_ready = (count_q != CNT_W'(DEPTH)) || issue_valid;
`else
  assign dispatch_ready = (count_q != CNT_W'(DEPTH));
`endif

  assign push = dispatch_valid && dispatch_ready && !flush;
  assign pop  = issue_valid;

  assign issue_info    = head.decode_info;
  assign issue_ps1     = head.ps1;
  assign issue_ps2     = head.ps2;
  assign issue_pd      = head.pd;
  assign issue_rob_idx = head.rob_idx;

  // JAL reads no registers, JALR reads only rs1.
  assign is_jal  = (dispatch_info.opcode == op_b_jal);
  assign is_jalr = (dispatch_info.opcode == op_b_jalr);
  assign d1_base = dispatch_ps1_rdy | (dispatch_ps1 == PREG_ZERO) | is_jal;
  assign d2_base = dispatch_ps2_rdy | (dispatch_ps2 == PREG_ZERO) | is_jal | is_jalr;

  // Same-cycle CDB bypass at write so a broadcast during dispatch is not lost.
  br_iq_wakeup #(.W(PHYS_REG_BITS)) u_wk_d1 (
    .tag_i(dispatch_ps1), .rdy_i(d1_base), .cdb_valid_i(cdb_valid), .cdb_pd_i(cdb_pd), .rdy_o(d1_rdy));
  br_iq_wakeup #(.W(PHYS_REG_BITS)) u_wk_d2 (
    .tag_i(dispatch_ps2), .rdy_i(d2_base), .cdb_valid_i(cdb_valid), .cdb_pd_i(cdb_pd), .rdy_o(d2_rdy));

  for (genvar i = 0; i < DEPTH; i++) begin : g_wk
    br_iq_wakeup #(.W(PHYS_REG_BITS)) u_wk1 (
      .tag_i(ent_q[i].ps1), .rdy_i(ent_q[i].ps1_rdy), .cdb_valid_i(cdb_valid & ent_q[i].valid),
      .cdb_pd_i(cdb_pd), .rdy_o(wk1[i]));
    br_iq_wakeup #(.W(PHYS_REG_BITS)) u_wk2 (
      .tag_i(ent_q[i].ps2), .rdy_i(ent_q[i].ps2_rdy), .cdb_valid_i(cdb_valid & ent_q[i].valid),
      .cdb_pd_i(cdb_pd), .rdy_o(wk2[i]));
  end

  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i].ps1_rdy = wk1[i];
      ent_d[i].ps2_rdy = wk2[i];
    end
    if (pop) begin
      ent_d[head_q].valid = 1'b0;
      head_d              = head_q + PTR_W'(1);
    end
    if (push) begin
      ent_d[tail_q].valid       = 1'b1;
      ent_d[tail_q].decode_info = dispatch_info;
      ent_d[tail_q].ps1         = dispatch_ps1;
      ent_d[tail_q].ps1_rdy     = d1_rdy;
      ent_d[tail_q].ps2         = dispatch_ps2;
      ent_d[tail_q].ps2_rdy     = d2_rdy;
      ent_d[tail_q].pd          = dispatch_pd;
      ent_d[tail_q].rob_idx     = dispatch_rob_idx;
      tail_d                    = tail_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (flush) begin
      ent_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_br_issue_queue.sv
// Scoreboard bench for br_issue_queue: accepted dispatches queue expectations, issues pop them.
module tb_br_issue_queue;
  import rv32i_types::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         dispatch_valid = 1'b0, dispatch_ready;
  decode_info_t dispatch_info = '0;
  logic [5:0]   dispatch_ps1 = '0, dispatch_ps2 = '0, dispatch_pd = '0;
  logic         dispatch_ps1_rdy = 1'b0, dispatch_ps2_rdy = 1'b0;
  logic [3:0]   dispatch_rob_idx = '0;
  logic         cdb_valid = 1'b0;
  logic [5:0]   cdb_pd = '0;
  logic         issue_ready = 1'b0, issue_valid;
  decode_info_t issue_info;
  logic [5:0]   issue_ps1, issue_ps2, issue_pd;
  logic [3:0]   issue_rob_idx;
  logic         flush = 1'b0;
  logic [2:0]   count;

  br_issue_queue #(.PHYS_REG_BITS(6), .ROB_IDX_BITS(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready), .dispatch_info(dispatch_info),
    .dispatch_ps1(dispatch_ps1), .dispatch_ps1_rdy(dispatch_ps1_rdy),
    .dispatch_ps2(dispatch_ps2), .dispatch_ps2_rdy(dispatch_ps2_rdy),
    .dispatch_pd(dispatch_pd), .dispatch_rob_idx(dispatch_rob_idx),
    .cdb_valid(cdb_valid), .cdb_pd(cdb_pd),
    .issue_ready(issue_ready), .issue_valid(issue_valid), .issue_info(issue_info),
    .issue_ps1(issue_ps1), .issue_ps2(issue_ps2), .issue_pd(issue_pd), .issue_rob_idx(issue_rob_idx),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] op;
    logic [5:0] ps1, ps2, pd;
    logic [3:0] rob;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Issue monitor: every issue must match the oldest outstanding dispatch.
  always @(negedge clk) begin
    if (!rst && issue_valid) begin
      if (sb.size() == 0) chk("spurious_issue", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("iss_rob", issue_rob_idx, e.rob);
        chk("iss_op",  issue_info.opcode, e.op);
        chk("iss_ps1", issue_ps1, e.ps1);
        chk("iss_ps2", issue_ps2, e.ps2);
        chk("iss_pd",  issue_pd, e.pd);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [6:0] op, input logic [2:0] f3,
                          input logic [5:0] p1, input logic r1, input logic [5:0] p2, input logic r2,
                          input logic [3:0] rob, input logic cv, input logic [5:0] cpd,
                          input logic exp_acc);
    exp_t e;
    dispatch_valid       = 1'b1;
    dispatch_info.opcode = op;
    dispatch_info.funct3 = f3;
    dispatch_info.pc     = {26'd0, rob, 2'b00};
    dispatch_info.imm    = 32'd16;
    dispatch_ps1 = p1; dispatch_ps1_rdy = r1;
    dispatch_ps2 = p2; dispatch_ps2_rdy = r2;
    dispatch_pd  = 6'(rob) + 6'd32;
    dispatch_rob_idx = rob;
    cdb_valid = cv; cdb_pd = cpd;
    #1;
    chk("dispatch_ready", dispatch_ready, exp_acc);
    if (exp_acc) begin
      e.op = op; e.ps1 = p1; e.ps2 = p2; e.pd = 6'(rob) + 6'd32; e.rob = rob;
      sb.push_back(e);
    end
    cyc();
    dispatch_valid = 1'b0;
    cdb_valid      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic full_pass;
`ifdef BR_ISSUE_QUEUE_FULL_PASS_EN
    full_pass = 1'b1;
`else
    full_pass = 1'b0;
`endif
    issue_ready = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_dready", dispatch_ready, 1);
    chk("rst_ivalid", issue_valid, 0);

    // Ready BEQ issues one cycle after dispatch
    dispatch(op_b_br, 3'b000, 6'd5, 1, 6'd7, 1, 4'd1, 0, 6'd0, 1);
    chk("beq_ivalid", issue_valid, 1);
    chk("beq_ps1", issue_ps1, 5);
    chk("beq_ps2", issue_ps2, 7);
    cyc();
    chk("beq_count", count, 0);

    // BNE waits for ps2=9; wakeup lands one cycle after broadcast
    dispatch(op_b_br, 3'b001, 6'd5, 1, 6'd9, 0, 4'd2, 0, 6'd0, 1);
    chk("bne_wait", issue_valid, 0);
    chk("bne_count", count, 1);
    cyc();
    cdb_valid = 1'b1; cdb_pd = 6'd9;
    #1;
    chk("bne_same_cyc", issue_valid, 0);
    cyc();
    cdb_valid = 1'b0;
    chk("bne_woken", issue_valid, 1);
    cyc();
    chk("bne_count0", count, 0);

    // BLT blocks a ready JAL behind it
    dispatch(op_b_br,  3'b100, 6'd3,  0, 6'd0,  0, 4'd3, 0, 6'd0, 1);
    dispatch(op_b_jal, 3'b000, 6'd20, 0, 6'd21, 0, 4'd4, 0, 6'd0, 1);
    chk("order_blocked", issue_valid, 0);
    chk("order_count", count, 2);
    cdb_valid = 1'b1; cdb_pd = 6'd3;
    cyc();
    cdb_valid = 1'b0;
    chk("order_blt", issue_rob_idx, 3);
    chk("order_blt_v", issue_valid, 1);
    cyc();
    chk("order_jal", issue_rob_idx, 4);
    chk("order_jal_v", issue_valid, 1);
    cyc();
    chk("order_count0", count, 0);

    // Fill to DEPTH with issue stalled
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      dispatch(op_b_br, 3'b000, 6'd1, 1, 6'd2, 1, 4'(5 + i), 0, 6'd0, 1);
    chk("full_count", count, 4);
    chk("full_dready", dispatch_ready, 0);
    dispatch(op_b_br, 3'b000, 6'd1, 1, 6'd2, 1, 4'd9, 0, 6'd0, 0);
    chk("full_reject", count, 4);
    issue_ready = 1'b1;
    dispatch(op_b_br, 3'b000, 6'd1, 1, 6'd2, 1, 4'd9, 0, 6'd0, full_pass);
    chk("full_pass_count", count, full_pass ? 4 : 3);
    for (int i = 0; i < 20 && count != 0; i++) cyc();
    chk("full_drain", count, 0);

    // Dispatch-time CDB bypass
    dispatch(op_b_jalr, 3'b000, 6'd12, 0, 6'd13, 0, 4'd10, 1, 6'd12, 1);
    chk("bypass_ivalid", issue_valid, 1);
    cyc();

    // Flush drops queued entries and the same-cycle dispatch
    issue_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      dispatch(op_b_br, 3'b000, 6'd1, 1, 6'd2, 1, 4'(10 + i), 0, 6'd0, 1);
    issue_ready = 1'b1;
    flush = 1'b1;
    dispatch_valid = 1'b1; dispatch_rob_idx = 4'd13;
    dispatch_ps1_rdy = 1'b1; dispatch_ps2_rdy = 1'b1;
    #1;
    chk("flush_no_issue", issue_valid, 0);
    sb.delete();
    cyc();
    flush = 1'b0; dispatch_valid = 1'b0;
    #1;
    chk("flush_count", count, 0);
    chk("flush_ivalid", issue_valid, 0);
    cyc();
    chk("flush_absent", count, 0);

    // Mid-operation reset
    issue_ready = 1'b0;
    dispatch(op_b_br, 3'b000, 6'd40, 0, 6'd41, 0, 4'd14, 0, 6'd0, 1);
    dispatch(op_b_br, 3'b000, 6'd42, 0, 6'd43, 0, 4'd15, 0, 6'd0, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sb.delete();
    issue_ready = 1'b1;
    #1;
    chk("mrst_count", count, 0);
    chk("mrst_dready", dispatch_ready, 1);
    chk("mrst_ivalid", issue_valid, 0);

    // Back-to-back push/pop across several pointer wraps
    for (int i = 0; i < 10; i++)
      dispatch(op_b_br, 3'(i), 6'(i + 1), 1, 6'(i + 2), 1, 4'(i), 0, 6'd0, 1);
    chk("wrap_last_v", issue_valid, 1);
    chk("wrap_last_rob", issue_rob_idx, 9);
    cyc();
    chk("wrap_count", count, 0);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
